// File: rtl/fetch_align_unit.sv
// Fetch front-end: IM line fetch, per-word RVC split, small instruction FIFO to decode.
// Build option FETCH_SKIP_ZERO_EN drops all-zero padding words before buffering.
module fetch_align_unit #(
   parameter int PC_W       = 6,
   parameter int LINE_W     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-2:0]   fetch_sel,
   input  logic [LINE_W-1:0] fetch_line,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_word,
   output logic [PC_W-1:0]   inst_pc,
   output logic              inst_is_c,
   output logic              halted
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_e;

   typedef struct packed {
      logic [31:0]     word;
      logic [PC_W-1:0] pc;
      logic            is_c;
   } ent_t;

   function automatic ent_t mk_ent(input logic [31:0] w,
                                   input logic [PC_W-1:0] pc);
      ent_t e;
      e.is_c = (w[1:0] != 2'b11);
      e.word = e.is_c ? {16'h0, w[15:0]} : w;
      e.pc   = pc;
      return e;
   endfunction

   state_e          state_q;
   logic [PC_W-2:0] line_ptr_q;
   logic            skip_first_q;
   logic            halted_q;

   ent_t            fifo_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   count_q, count_d;

   logic [31:0]     slot0, slot1;
   ent_t            ent0, ent1, e0, head;
   logic            keep0, keep1;
   logic [CW-1:0]   free_cnt;
   logic            cap, pop;
   logic [1:0]      n_push;

   assign slot0 = fetch_line[LINE_W-1 -: 32];
   assign slot1 = fetch_line[31:0];
   assign ent0  = mk_ent(slot0, {line_ptr_q, 1'b0});
   assign ent1  = mk_ent(slot1, {line_ptr_q, 1'b1});

   always_comb begin
      keep0 = !skip_first_q;
      keep1 = 1'b1;
`ifdef FETCH_SKIP_ZERO_EN
      keep0 = keep0 && (slot0 != 32'h0);
      keep1 = (slot1 != 32'h0);
`endif
   end

   // Free space is judged before the same-cycle pop.
   assign free_cnt = DEPTH_C - count_q;
   assign pop      = inst_valid && inst_ready;
   assign cap      = (state_q == FETCH) && (free_cnt >= CW'(2));
   assign n_push   = cap ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;
   assign e0       = keep0 ? ent0 : ent1;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (redirect_valid) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         wr_d    = wr_q + AW'(n_push);
         rd_d    = rd_q + AW'(pop);
         count_d = count_q + CW'(n_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!redirect_valid) begin
         if (n_push != 2'd0) fifo_q[wr_q] <= e0;
         if (n_push == 2'd2) fifo_q[wr_q + 1'b1] <= ent1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         line_ptr_q   <= '0;
         skip_first_q <= 1'b0;
         halted_q     <= 1'b0;
      end else if (redirect_valid) begin
         state_q      <= FETCH;
         line_ptr_q   <= redirect_pc[PC_W-1:1];
         skip_first_q <= redirect_pc[0];
         halted_q     <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (cap) begin
                  skip_first_q <= 1'b0;
                  if (&line_ptr_q) state_q <= DRAIN;
                  else line_ptr_q <= line_ptr_q + 1'b1;
               end
            end
            DRAIN: begin
               if (count_d == '0) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end
            end
            HALT: ;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Stale entries are masked so idle outputs read as zero.
   assign head       = fifo_q[rd_q];
   assign inst_valid = (count_q != '0);
   assign inst_word  = inst_valid ? head.word : 32'h0;
   assign inst_pc    = inst_valid ? head.pc : '0;
   assign inst_is_c  = inst_valid && head.is_c;
   assign fetch_sel  = line_ptr_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_align_unit.sv
// Directed bench for fetch_align_unit: queue-based program-order model
// compared every cycle, plus hand-computed literal expectations.
module tb_fetch_align_unit;
   localparam int PC_W = 6;

`ifdef FETCH_SKIP_ZERO_EN
   localparam bit SKZ = 1'b1;
`else
   localparam bit SKZ = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [PC_W-2:0] fetch_sel;
   logic [63:0]     fetch_line;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic            inst_valid;
   logic            inst_ready = 1'b0;
   logic [31:0]     inst_word;
   logic [PC_W-1:0] inst_pc;
   logic            inst_is_c;
   logic            halted;

   logic [63:0]     im [32];
   int              checks = 0;
   int              errors = 0;
   bit              model_on = 1'b0;

   logic [31:0]     mq_w [$];
   int              mq_pc [$];
   int              m_ptr;
   bit              m_skip;
   int              m_st;

   fetch_align_unit dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_sel      (fetch_sel),
      .fetch_line     (fetch_line),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_word      (inst_word),
      .inst_pc        (inst_pc),
      .inst_is_c      (inst_is_c),
      .halted         (halted)
   );

   assign fetch_line = im[fetch_sel];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit keep(input logic [31:0] w);
      return !(SKZ && (w == 32'h0));
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] w);
      return (w[1:0] != 2'b11) ? {16'h0, w[15:0]} : w;
   endfunction

   task automatic model_reset();
      mq_w.delete();
      mq_pc.delete();
      m_ptr  = 0;
      m_skip = 1'b0;
      m_st   = 0;
   endtask

   // m_st: 0 fetching, 1 draining, 2 halted
   task automatic model_step(input bit rv, input logic [PC_W-1:0] rpc,
                             input bit rdy);
      logic [63:0] ln;
      int free;
      if (rv) begin
         mq_w.delete();
         mq_pc.delete();
         m_ptr  = int'(rpc[PC_W-1:1]);
         m_skip = rpc[0];
         m_st   = 0;
         return;
      end
      free = 4 - mq_w.size();
      if (mq_w.size() > 0 && rdy) begin
         void'(mq_w.pop_front());
         void'(mq_pc.pop_front());
      end
      if (m_st == 0 && free >= 2) begin
         ln = im[m_ptr];
         if (!m_skip && keep(ln[63:32])) begin
            mq_w.push_back(ln[63:32]);
            mq_pc.push_back(2 * m_ptr);
         end
         if (keep(ln[31:0])) begin
            mq_w.push_back(ln[31:0]);
            mq_pc.push_back(2 * m_ptr + 1);
         end
         m_skip = 1'b0;
         if (m_ptr == 31) m_st = 1;
         else m_ptr++;
      end else if (m_st == 1 && mq_w.size() == 0) begin
         m_st = 2;
      end
   endtask

   task automatic cyc(input bit rv, input logic [PC_W-1:0] rpc,
                      input bit rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      @(posedge clk);
      model_step(rv, rpc, rdy);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (model_on && reset) begin
         chk("fetch_sel", 32'(fetch_sel), 32'(m_ptr));
         chk("halted", 32'(halted), 32'(m_st == 2));
         chk("inst_valid", 32'(inst_valid), 32'(mq_w.size() > 0));
         if (mq_w.size() > 0) begin
            chk("inst_pc", 32'(inst_pc), 32'(mq_pc[0]));
            chk("inst_word", inst_word, exp_word(mq_w[0]));
            chk("inst_is_c", 32'(inst_is_c), 32'(mq_w[0][1:0] != 2'b11));
         end
      end
   end

   initial begin
      int exp_pc [4] = '{13, 14, 15, 16};
      int n;
      for (int i = 0; i < 32; i++) begin
         im[i][63:32] = {16'hA5A0 | 16'(i), 16'h1000 + 16'(i * 4)};
         im[i][31:0]  = 32'h13 | (32'(i) << 7) | (32'(i) << 20);
      end
      im[0]  = {32'h0000_0000, 32'h0000_40F9};
      im[4]  = {32'h0040_0093, 32'h0000_8082};
      im[5]  = {32'h1234_5671, 32'hABCD_EF02};
      im[6]  = {32'h41C2_5093, 32'h0031_0133};
      im[10] = 64'h0;

      model_reset();
      #3;
      chk("rst_sel", 32'(fetch_sel), 0);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_word", inst_word, 0);
      chk("rst_pc", 32'(inst_pc), 0);
      chk("rst_is_c", 32'(inst_is_c), 0);
      @(negedge clk);
      reset = 1'b1;
      model_on = 1'b1;

      // first line, with zero word in slot0
      cyc(1'b0, '0, 1'b1);
      chk("t2_valid", 32'(inst_valid), 1);
      chk("t2_sel", 32'(fetch_sel), 1);
`ifdef FETCH_SKIP_ZERO_EN
      chk("t2_word", inst_word, 32'h0000_40F9);
      chk("t2_pc", 32'(inst_pc), 1);
      chk("t2_is_c", 32'(inst_is_c), 1);
`else
      chk("t2_word0", inst_word, 32'h0);
      chk("t2_pc0", 32'(inst_pc), 0);
      chk("t2_is_c0", 32'(inst_is_c), 1);
      cyc(1'b0, '0, 1'b1);
      chk("t2_word1", inst_word, 32'h0000_40F9);
      chk("t2_pc1", 32'(inst_pc), 1);
      chk("t2_is_c1", 32'(inst_is_c), 1);
`endif

      // backpressure from a clean FIFO at line 6
      cyc(1'b1, 6'd12, 1'b0);
      chk("t4_rd_valid", 32'(inst_valid), 0);
      chk("t4_rd_sel", 32'(fetch_sel), 6);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);
      chk("t4_sel_frozen", 32'(fetch_sel), 8);
      chk("t4_valid", 32'(inst_valid), 1);
      chk("t3_pc12", 32'(inst_pc), 12);
      chk("t3_word12", inst_word, 32'h41C2_5093);
      chk("t3_is_c12", 32'(inst_is_c), 0);
      cyc(1'b0, '0, 1'b1);
      chk("t3_word13", inst_word, 32'h0031_0133);
      chk("t3_is_c13", 32'(inst_is_c), 0);
      chk("t4_pop0", 32'(inst_pc), 32'(exp_pc[0]));
      for (int i = 1; i < 4; i++) begin
         cyc(1'b0, '0, 1'b1);
         chk("t4_pop", 32'(inst_pc), 32'(exp_pc[i]));
      end

      // redirect to pc 8, fill two, then redirect to pc 9 while popping
      cyc(1'b1, 6'd8, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("t5_pre_pc", 32'(inst_pc), 8);
      chk("t5_pre_sel", 32'(fetch_sel), 5);
      cyc(1'b1, 6'd9, 1'b1);
      chk("t5_empty", 32'(inst_valid), 0);
      chk("t5_sel", 32'(fetch_sel), 4);
      cyc(1'b0, '0, 1'b0);
      chk("t5_pc9", 32'(inst_pc), 9);
      chk("t5_word9", inst_word, 32'h0000_8082);
      chk("t5_is_c9", 32'(inst_is_c), 1);
      cyc(1'b0, '0, 1'b1);
      chk("t5_pc10", 32'(inst_pc), 10);
      chk("t5_word10", inst_word, 32'h0000_5671);
      cyc(1'b0, '0, 1'b1);
      chk("t5_pc11", 32'(inst_pc), 11);
      chk("t5_word11", inst_word, 32'h0000_EF02);
      chk("t5_is_c11", 32'(inst_is_c), 1);

      // run to end of program
      n = 0;
      while (!halted && n < 300) begin
         cyc(1'b0, '0, 1'b1);
         n++;
      end
      chk("t6_halted", 32'(halted), 1);
      chk("t6_valid", 32'(inst_valid), 0);
      chk("t6_sel", 32'(fetch_sel), 31);
      cyc(1'b0, '0, 1'b1);
      chk("t6_stay", 32'(halted), 1);
      cyc(1'b1, 6'd0, 1'b0);
      chk("t6_unhalt", 32'(halted), 0);
      chk("t6_sel0", 32'(fetch_sel), 0);
      cyc(1'b0, '0, 1'b0);
      chk("t6_refetch_sel", 32'(fetch_sel), 1);
      chk("t6_refetch_valid", 32'(inst_valid), 1);

      // asynchronous reset with three entries buffered
      cyc(1'b1, 6'd1, 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("t1_pre_pc", 32'(inst_pc), 1);
      chk("t1_pre_sel", 32'(fetch_sel), 2);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("t1_valid", 32'(inst_valid), 0);
      chk("t1_sel", 32'(fetch_sel), 0);
      chk("t1_halted", 32'(halted), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
